// File: rtl/frame_capture_ctrl.sv
// OV7670 capture sequencer: synchronises the camera bus, packs RGB565 byte pairs into
// RGB332 and drives frame-buffer writes in single-shot or continuous mode.
module frame_capture_ctrl #(
  parameter int unsigned WIDTH  = 176,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic              ARM,
  input  logic              CONTINUOUS,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic [CNT_W-1:0]  FRAME_COUNT
);

  localparam int unsigned X_W = $clog2(WIDTH + 1);
  localparam int unsigned Y_W = $clog2(HEIGHT + 1);
  localparam int unsigned L_W = $clog2(HEIGHT + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VSYNC,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Camera-domain synchronisers and per-PCLK-edge samples
  logic       pclk_meta_q, pclk_sync_q, pclk_prev_q;
  logic       href_meta_q, href_sync_q, href_smp_q;
  logic       vs_meta_q, vs_sync_q, vs_smp_q;
  logic [7:0] data_meta_q, data_sync_q;

  logic pclk_edge;
  logic vs_rise;
  logic href_fall;
  logic href_byte;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [L_W-1:0]      lines_q, lines_d;
  logic                phase_q, phase_d;
  logic [1:0]          blue_q, blue_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [7:0]          w_data_q, w_data_d;
  logic                w_en_q, w_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                clear_frame;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pclk_meta_q <= 1'b0;
      pclk_sync_q <= 1'b0;
      pclk_prev_q <= 1'b0;
      href_meta_q <= 1'b0;
      href_sync_q <= 1'b0;
      href_smp_q  <= 1'b0;
      vs_meta_q   <= 1'b0;
      vs_sync_q   <= 1'b0;
      vs_smp_q    <= 1'b0;
      data_meta_q <= 8'd0;
      data_sync_q <= 8'd0;
    end else begin
      pclk_meta_q <= CAM_PCLK;
      pclk_sync_q <= pclk_meta_q;
      pclk_prev_q <= pclk_sync_q;
      href_meta_q <= CAM_HREF;
      href_sync_q <= href_meta_q;
      vs_meta_q   <= CAM_VSYNC;
      vs_sync_q   <= vs_meta_q;
      data_meta_q <= CAM_DATA;
      data_sync_q <= data_meta_q;
      if (pclk_edge) begin
        href_smp_q <= href_sync_q;
        vs_smp_q   <= vs_sync_q;
      end
    end
  end

  assign pclk_edge = pclk_sync_q & ~pclk_prev_q;
  assign vs_rise   = pclk_edge & vs_sync_q & ~vs_smp_q;
  assign href_fall = pclk_edge & ~href_sync_q & href_smp_q;
  assign href_byte = pclk_edge & href_sync_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      base_q   <= '0;
      lines_q  <= '0;
      phase_q  <= 1'b0;
      blue_q   <= 2'd0;
      w_addr_q <= '0;
      w_data_q <= 8'd0;
      w_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      base_q   <= base_d;
      lines_q  <= lines_d;
      phase_q  <= phase_d;
      blue_q   <= blue_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    lines_d     = lines_q;
    phase_d     = phase_q;
    blue_d      = blue_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    w_en_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    count_d     = count_q;
    clear_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ARM || CONTINUOUS) state_d = ST_WAIT_VSYNC;
      end

      ST_WAIT_VSYNC: begin
        if (vs_rise) begin
          state_d     = ST_CAPTURE;
          clear_frame = 1'b1;
        end
      end

      ST_CAPTURE: begin
        // Frame end takes priority over any byte sampled on the same edge
        if (vs_rise) begin
          done_d      = 1'b1;
          count_d     = count_q + CNT_W'(1);
          err_d       = (lines_q != L_W'(HEIGHT));
          clear_frame = 1'b1;
          if (!CONTINUOUS) state_d = ST_DONE;
        end else if (href_fall) begin
          x_d     = '0;
          phase_d = 1'b0;
          if (lines_q != L_W'(HEIGHT + 1)) lines_d = lines_q + L_W'(1);
          if (y_q != Y_W'(HEIGHT)) begin
            y_d    = y_q + Y_W'(1);
            base_d = base_q + ADDR_W'(WIDTH);
          end
        end else if (href_byte) begin
          if (!phase_q) begin
            blue_d  = data_sync_q[4:3];
            phase_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            w_data_d = {data_sync_q[7:5], data_sync_q[2:0], blue_q};
            if ((x_q < X_W'(WIDTH)) && (y_q < Y_W'(HEIGHT))) begin
              w_en_d   = 1'b1;
              w_addr_d = base_q + ADDR_W'(x_q);
            end
            if (x_q != X_W'(WIDTH)) x_d = x_q + X_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (ARM || CONTINUOUS) state_d = ST_WAIT_VSYNC;
      end

      default: state_d = ST_IDLE;
    endcase

    if (clear_frame) begin
      x_d     = '0;
      y_d     = '0;
      base_d  = '0;
      lines_d = '0;
      phase_d = 1'b0;
    end

    busy_d = (state_d == ST_WAIT_VSYNC) || (state_d == ST_CAPTURE);
  end

  assign W_ADDR      = w_addr_q;
  assign W_DATA      = w_data_q;
  assign W_EN        = w_en_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ERR   = err_q;
  assign FRAME_COUNT = count_q;

endmodule
